// File: rtl/arb_ingress_queue_if.sv
// Handshake bundle for arb_ingress_queue: per-requester push side, arbiter req/gnt pair,
// and the single registered output stage.
interface arb_ingress_queue_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_ready;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            gnt;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [PTR_WIDTH-1:0]          out_src;
    logic                          out_ready;

    modport master (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, req, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, req, out_valid, out_data, out_src
    );
endinterface

// File: rtl/arb_ingress_queue.sv
// Per-requester ingress FIFOs feeding a round-robin arbiter; winner lands in one output register.
// Latency 2 cycles push-to-out_valid; req is withheld while the output word is stalled.
module arb_ingress_queue #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    arb_ingress_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q  [NUM_REQ][DEPTH];
    logic [AW-1:0]         wptr_q [NUM_REQ];
    logic [AW-1:0]         wptr_d [NUM_REQ];
    logic [AW-1:0]         rptr_q [NUM_REQ];
    logic [AW-1:0]         rptr_d [NUM_REQ];
    logic [CW-1:0]         cnt_q  [NUM_REQ];
    logic [CW-1:0]         cnt_d  [NUM_REQ];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [PTR_WIDTH-1:0]  out_src_q,   out_src_d;

    logic [NUM_REQ-1:0]    in_ready_c;
    logic [NUM_REQ-1:0]    req_c;
    logic [NUM_REQ-1:0]    push;
    logic [NUM_REQ-1:0]    pop;
    logic                  load_ok;

    // req is gated by output availability so every grant is a guaranteed transfer
    always_comb begin
        load_ok    = !out_valid_q || bus.out_ready;
        in_ready_c = '0;
        req_c      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ready_c[i] = !rst && (cnt_q[i] < CW'(DEPTH));
            req_c[i]      = !rst && (cnt_q[i] != '0) && load_ok;
        end
    end

    assign push = bus.in_valid & in_ready_c;
    assign pop  = bus.gnt & req_c;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            wptr_d[i] = wptr_q[i] + AW'(push[i]);
            rptr_d[i] = rptr_q[i] + AW'(pop[i]);
            cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            if (pop[i]) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[i][rptr_q[i]];
                out_src_d   = PTR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.req       = req_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    gnt_subset: assert property (@(posedge clk) disable iff (rst) (bus.gnt & ~bus.req) == '0);
endmodule

// File: tb/tb_arb_ingress_queue.sv
// Bench for arb_ingress_queue: round-robin arbiter stand-in, queue-based reference model,
// vector table for the basic push path, directed corner sequences, then random traffic.
module tb_arb_ingress_queue;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arb_ingress_queue_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    arb_ingress_queue #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Round-robin arbiter: search starts just after the last granted index
    logic [1:0]   arb_ptr;
    logic [N-1:0] gnt_c;
    logic [1:0]   gnt_idx;
    logic [1:0]   cand;
    always_comb begin
        gnt_c   = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = arb_ptr + 2'(k);
            if (gnt_c == '0 && bus.req[cand]) begin
                gnt_c[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end
    assign bus.gnt = gnt_c;
    always_ff @(posedge clk) begin
        if (rst) arb_ptr <= '0;
        else if (gnt_c != '0) arb_ptr <= gnt_idx;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one queue per requester plus the output word
    logic [7:0] mq [N][$];
    bit         mv;
    logic [7:0] md;
    logic [1:0] ms;
    int log_src[$];
    int log_dat[$];
    int log_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] er, eir, popv;
        bit ld;
        ld = !mv || bus.out_ready;
        for (int i = 0; i < N; i++) begin
            eir[i] = !rst && (mq[i].size() < 4);
            er[i]  = !rst && (mq[i].size() != 0) && ld;
        end
        chk("model_in_ready", 32'(bus.in_ready), 32'(eir));
        chk("model_req", 32'(bus.req), 32'(er));
        chk("model_out_valid", 32'(bus.out_valid), 32'(mv));
        chk("model_out_data", 32'(bus.out_data), 32'(md));
        chk("model_out_src", 32'(bus.out_src), 32'(ms));
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mv = 1'b0;
            md = '0;
            ms = '0;
        end else begin
            if (mv && bus.out_ready) begin
                log_src.push_back(int'(ms));
                log_dat.push_back(int'(md));
                log_cyc.push_back(cyc);
                mv = 1'b0;
            end
            popv = bus.gnt & er;
            for (int i = 0; i < N; i++) begin
                if (popv[i]) begin
                    md = mq[i].pop_front();
                    ms = 2'(i);
                    mv = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.in_valid[i] && eir[i]) mq[i].push_back(bus.in_data[i*DW +: DW]);
            end
        end
    endtask

    // Drive one cycle's inputs on the falling edge and check just after, before the rising edge
    task automatic step(input logic r, input logic [N-1:0] iv, input logic [31:0] dat, input logic ordy);
        @(negedge clk);
        cyc++;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = dat;
        bus.out_ready = ordy;
        #1;
        model_cycle();
    endtask

    function automatic logic [31:0] pack_all(input int k);
        return {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
    endfunction

    task automatic clear_log();
        log_src.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] iv;
        logic [31:0]  dat;
        logic         ordy;
        logic [N-1:0] e_ir;
        logic [N-1:0] e_req;
        logic         e_ov;
        logic [7:0]   e_od;
        logic [1:0]   e_os;
    } vec_t;
    vec_t tbl [5];

    initial begin
        tbl[0] = '{1'b1, 4'b0000, 32'h0,         1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 4'b0100, 32'h00A50000,  1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{1'b0, 4'b0000, 32'h0,         1'b1, 4'b1111, 4'b0100, 1'b0, 8'h00, 2'd0};
        tbl[3] = '{1'b0, 4'b0000, 32'h0,         1'b1, 4'b1111, 4'b0000, 1'b1, 8'hA5, 2'd2};
        tbl[4] = '{1'b0, 4'b0000, 32'h0,         1'b1, 4'b1111, 4'b0000, 1'b0, 8'hA5, 2'd2};

        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        mv = 1'b0;
        md = '0;
        ms = '0;
        repeat (2) @(posedge clk);

        // Reset state and single push on requester 2
        for (int v = 0; v < 5; v++) begin
            step(tbl[v].r, tbl[v].iv, tbl[v].dat, tbl[v].ordy);
            chk($sformatf("vec%0d_in_ready", v), 32'(bus.in_ready), 32'(tbl[v].e_ir));
            chk($sformatf("vec%0d_req", v), 32'(bus.req), 32'(tbl[v].e_req));
            chk($sformatf("vec%0d_out_valid", v), 32'(bus.out_valid), 32'(tbl[v].e_ov));
            chk($sformatf("vec%0d_out_data", v), 32'(bus.out_data), 32'(tbl[v].e_od));
            chk($sformatf("vec%0d_out_src", v), 32'(bus.out_src), 32'(tbl[v].e_os));
        end

        // Round-robin fairness: two words per FIFO, drained back-to-back
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 4'b1111, pack_all(0), 1'b0);
        step(1'b0, 4'b1111, pack_all(1), 1'b0);
        clear_log();
        repeat (10) step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("rr_count", 32'(log_src.size()), 32'd8);
        for (int n = 0; n < 8 && n < log_src.size(); n++) begin
            chk($sformatf("rr_src%0d", n), 32'(log_src[n]), 32'((n + 1) % 4));
            chk($sformatf("rr_data%0d", n), 32'(log_dat[n]), 32'(((n + 1) % 4) * 16 + n / 4));
            if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(log_cyc[n] - log_cyc[n-1]), 32'd1);
        end

        // Backpressure: stalled output freezes req, gnt and the output word
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 4'b1011, pack_all(0), 1'b0);
        step(1'b0, 4'b1011, pack_all(1), 1'b0);
        clear_log();
        for (int s = 0; s < 10; s++) begin
            step(1'b0, 4'b0000, 32'h0, 1'b0);
            chk("bp_req", 32'(bus.req), 32'd0);
            chk("bp_gnt", 32'(bus.gnt), 32'd0);
            chk("bp_out_data", 32'(bus.out_data), 32'h10);
            chk("bp_out_src", 32'(bus.out_src), 32'd1);
        end
        repeat (8) step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("bp_count", 32'(log_src.size()), 32'd6);
        if (log_src.size() >= 3) begin
            chk("bp_first_src", 32'(log_src[0]), 32'd1);
            chk("bp_next_src", 32'(log_src[1]), 32'd3);
            chk("bp_third_src", 32'(log_src[2]), 32'd0);
        end

        // Full FIFO on requester 0 with the output register occupied
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 4'b0010, pack_all(0), 1'b0);
        step(1'b0, 4'b0000, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0001, pack_all(k), 1'b0);
            chk($sformatf("full_in_ready_push%0d", k), 32'(bus.in_ready[0]), (k < 4) ? 32'd1 : 32'd0);
        end
        clear_log();
        repeat (10) step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("full_count", 32'(log_src.size()), 32'd5);
        if (log_src.size() == 5) begin
            chk("full_first_src", 32'(log_src[0]), 32'd1);
            for (int n = 1; n < 5; n++) begin
                chk($sformatf("full_src%0d", n), 32'(log_src[n]), 32'd0);
                chk($sformatf("full_data%0d", n), 32'(log_dat[n]), 32'(n - 1));
            end
        end

        // Simultaneous push and pop on requester 1
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        clear_log();
        step(1'b0, 4'b0010, pack_all(0), 1'b0);
        step(1'b0, 4'b0010, pack_all(1), 1'b0);
        step(1'b0, 4'b0010, pack_all(2), 1'b0);
        for (int k = 3; k <= 10; k++) begin
            step(1'b0, 4'b0010, pack_all(k), 1'b1);
            chk("pp_req", 32'(bus.req), 32'b0010);
            chk("pp_in_ready", 32'(bus.in_ready[1]), 32'd1);
        end
        repeat (5) step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("pp_count", 32'(log_dat.size()), 32'd11);
        for (int n = 0; n < 11 && n < log_dat.size(); n++) begin
            chk($sformatf("pp_order%0d", n), 32'(log_dat[n]), 32'(16 + n));
        end

        // Reset mid-stream discards queued and pending words
        step(1'b0, 4'b1111, pack_all(0), 1'b0);
        step(1'b0, 4'b1111, pack_all(1), 1'b0);
        step(1'b1, 4'b1111, pack_all(2), 1'b1);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_req", 32'(bus.req), 32'd0);
        clear_log();
        repeat (5) step(1'b0, 4'b0000, 32'h0, 1'b1);
        chk("mid_rst_no_output", 32'(log_src.size()), 32'd0);

        // Random traffic against the model
        for (int t = 0; t < 600; t++) begin
            step(($urandom_range(0, 63) == 0), 4'($urandom), $urandom, ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
